// File: rtl/manchester_frame_tx.sv
// Manchester frame transmitter: preamble, SFD, payload and optional CRC-32 FCS, followed by an inter-frame gap.
// Optional FCS stage is compiled in with macro MANCHESTER_TX_FCS_EN.
module manchester_frame_tx #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_CYCLES     = 192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       encoded,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int BCNT_W = ($clog2(PREAMBLE_BYTES + 1) > 2) ? $clog2(PREAMBLE_BYTES + 1) : 2;
    localparam int GCNT_W = ($clog2(IFG_CYCLES + 1) > 1) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [BCNT_W-1:0] PRE_LAST = BCNT_W'(PREAMBLE_BYTES - 1);
    localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_PAYLOAD  = 3'd3,
`ifdef MANCHESTER_TX_FCS_EN
        ST_FCS      = 3'd4,
`endif
        ST_GAP      = 3'd5
    } state_t;

    // bit 0 -> "10", bit 1 -> "01"; hcnt[0] selects the half
    function automatic logic manchester_half(input logic [7:0] data_byte, input logic [3:0] hcnt);
        return ~(data_byte[hcnt[3:1]] ^ hcnt[0]);
    endfunction

`ifdef MANCHESTER_TX_FCS_EN
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data_byte);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    logic [31:0] crc_q, crc_d, fcs_s;
`endif

    state_t              state_q, state_d;
    logic [3:0]          hcnt_q, hcnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic [7:0]          hold_data_q, hold_data_d;
    logic                hold_last_q, hold_last_d;
    logic                tx_ready_q, tx_ready_d;
    logic                encoded_q, encoded_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;
    logic                accept_s, byte_end_s, line_on_s;
    logic [7:0]          cur_byte_s;

    assign tx_ready   = tx_ready_q;
    assign encoded    = encoded_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    // Next-state, counter and hold-register logic
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        bcnt_d      = bcnt_q;
        gcnt_d      = gcnt_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        underrun_d  = 1'b0;
`ifdef MANCHESTER_TX_FCS_EN
        crc_d       = crc_q;
`endif
        accept_s    = tx_valid && tx_ready_q;
        byte_end_s  = (hcnt_q == 4'd15);
        case (state_q)
            ST_IDLE: begin
                hcnt_d = 4'd0;
                bcnt_d = '0;
                gcnt_d = '0;
                if (accept_s) begin
                    hold_data_d = tx_data;
                    hold_last_d = tx_last;
                    state_d     = ST_PREAMBLE;
`ifdef MANCHESTER_TX_FCS_EN
                    crc_d       = 32'hFFFFFFFF;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                hcnt_d = hcnt_q + 4'd1;
                if (byte_end_s && (bcnt_q == PRE_LAST)) begin
                    bcnt_d  = '0;
                    state_d = ST_SFD;
                end else if (byte_end_s) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            ST_SFD: begin
                hcnt_d = hcnt_q + 4'd1;
                if (byte_end_s) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_SFD;
                end
            end
            ST_PAYLOAD: begin
                hcnt_d = hcnt_q + 4'd1;
                if (byte_end_s) begin
`ifdef MANCHESTER_TX_FCS_EN
                    crc_d = crc32_byte(crc_q, hold_data_q);
`endif
                    if (hold_last_q) begin
`ifdef MANCHESTER_TX_FCS_EN
                        bcnt_d  = '0;
                        state_d = ST_FCS;
`else
                        gcnt_d  = '0;
                        state_d = ST_GAP;
`endif
                    end else if (accept_s) begin
                        hold_data_d = tx_data;
                        hold_last_d = tx_last;
                    end else begin
                        gcnt_d     = '0;
                        underrun_d = 1'b1;
                        state_d    = ST_GAP;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
`ifdef MANCHESTER_TX_FCS_EN
            ST_FCS: begin
                hcnt_d = hcnt_q + 4'd1;
                if (byte_end_s && (bcnt_q[1:0] == 2'd3)) begin
                    gcnt_d  = '0;
                    state_d = ST_GAP;
                end else if (byte_end_s) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
`endif
            ST_GAP: begin
                hcnt_d = 4'd0;
                if (gcnt_q == GAP_LAST) begin
                    gcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are derived from next-state values so the registered line lines up with the state
    always_comb begin
        cur_byte_s = 8'h00;
        line_on_s  = 1'b1;
`ifdef MANCHESTER_TX_FCS_EN
        fcs_s      = ~crc_d;
`endif
        case (state_d)
            ST_PREAMBLE: cur_byte_s = 8'h55;
            ST_SFD:      cur_byte_s = 8'hD5;
            ST_PAYLOAD:  cur_byte_s = hold_data_d;
`ifdef MANCHESTER_TX_FCS_EN
            ST_FCS: begin
                case (bcnt_d[1:0])
                    2'd0:    cur_byte_s = fcs_s[7:0];
                    2'd1:    cur_byte_s = fcs_s[15:8];
                    2'd2:    cur_byte_s = fcs_s[23:16];
                    default: cur_byte_s = fcs_s[31:24];
                endcase
            end
`endif
            default:     line_on_s  = 1'b0;
        endcase
        encoded_d  = line_on_s ? manchester_half(cur_byte_s, hcnt_d) : 1'b0;
        tx_ready_d = (state_d == ST_IDLE) ||
                     ((state_d == ST_PAYLOAD) && (hcnt_d == 4'd15) && !hold_last_d);
        busy_d     = (state_d != ST_IDLE);
`ifdef MANCHESTER_TX_FCS_EN
        frame_done_d = (state_d == ST_FCS) && (hcnt_d == 4'd15) && (bcnt_d[1:0] == 2'd3);
`else
        frame_done_d = (state_d == ST_PAYLOAD) && (hcnt_d == 4'd15) && hold_last_d;
`endif
    end

    // State, counters, hold register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hcnt_q       <= 4'd0;
            bcnt_q       <= '0;
            gcnt_q       <= '0;
            hold_data_q  <= 8'h00;
            hold_last_q  <= 1'b0;
            tx_ready_q   <= 1'b1;
            encoded_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef MANCHESTER_TX_FCS_EN
            crc_q        <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            bcnt_q       <= bcnt_d;
            gcnt_q       <= gcnt_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            tx_ready_q   <= tx_ready_d;
            encoded_q    <= encoded_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
`ifdef MANCHESTER_TX_FCS_EN
            crc_q        <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Self-checking bench for manchester_frame_tx: per-cycle frame model plus literal pins on the captured line.
module tb_manchester_frame_tx;

    localparam int PRE = 7;
    localparam int IFG = 192;
`ifdef MANCHESTER_TX_FCS_EN
    localparam bit FCS = 1'b1;
`else
    localparam bit FCS = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       encoded;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    manchester_frame_tx #(.PREAMBLE_BYTES(PRE), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .encoded(encoded), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    typedef struct packed { logic enc; logic rdy; logic bsy; logic fd; logic ur; } exp_t;

    exp_t exp_q[$];
    logic enc_log[$];
    logic rdy_log[$];
    logic fd_log[$];
    logic ur_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t cmp_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // CRC-32 computed MSB-first with the normal polynomial on bit-reversed input
    function automatic logic [31:0] crc32_model(input logic [7:0] msg[$]);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (msg[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ msg[k][i];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    function automatic logic [15:0] halves(input int start);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15-i] = enc_log[start+i];
        return r;
    endfunction

    function automatic logic [7:0] dec_byte(input int start);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = enc_log[start + 2*j + 1];
        return r;
    endfunction

    function automatic int first_from(input logic q[$], input int lo);
        for (int i = lo; i < q.size(); i++) if (q[i]) return i;
        return -1;
    endfunction

    function automatic int count_range(input logic q[$], input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi && i < q.size(); i++) if (q[i]) n++;
        return n;
    endfunction

    // Compare DUT outputs against the model once per queued cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            chk($sformatf("cycle %0d {enc,rdy,bsy,fd,ur}", enc_log.size()),
                {27'd0, encoded, tx_ready, busy, frame_done, underrun}, {27'd0, cmp_e});
            enc_log.push_back(encoded);
            rdy_log.push_back(tx_ready);
            fd_log.push_back(frame_done);
            ur_log.push_back(underrun);
        end
    end

    // Drive one frame; drop>=0 withholds the byte after payload index drop, rst_at>=0 pulses rst in that cycle
    task automatic run_frame(input logic [7:0] pay[$], input int drop, input int rst_at);
        logic [7:0]  L[$];
        logic [7:0]  cur;
        logic [31:0] crc;
        exp_t        e;
        int          n, np, nl, total, nxt, lim, k, bi, h, pj;
        logic        v, bitv;
        n  = pay.size();
        np = (drop >= 0) ? drop + 1 : n;
        for (int i = 0; i < PRE; i++) L.push_back(8'h55);
        L.push_back(8'hD5);
        for (int i = 0; i < np; i++) L.push_back(pay[i]);
        if (FCS && drop < 0) begin
            crc = crc32_model(pay);
            for (int i = 0; i < 4; i++) L.push_back(crc[8*i +: 8]);
        end
        nl    = L.size();
        total = (rst_at >= 0) ? rst_at + 4 : 1 + 16*nl + IFG + 1;
        enc_log.delete(); rdy_log.delete(); fd_log.delete(); ur_log.delete();
        nxt = 0;
        lim = (drop >= 0) ? drop + 1 : n;
        for (int c = 0; c < total; c++) begin
            e = '{enc: 1'b0, rdy: 1'b1, bsy: 1'b0, fd: 1'b0, ur: 1'b0};
            if ((rst_at >= 0 && c > rst_at) || c == 0 || c > 16*nl + IFG) begin
                e = '{enc: 1'b0, rdy: 1'b1, bsy: 1'b0, fd: 1'b0, ur: 1'b0};
            end else if (c <= 16*nl) begin
                k    = c - 1;
                bi   = k / 16;
                h    = k % 16;
                cur  = L[bi];
                bitv = cur[h/2];
                pj   = bi - (PRE + 1);
                e.enc = (h % 2 == 1) ? bitv : !bitv;
                e.rdy = (pj >= 0) && (pj < np) && (pj < n - 1) && (h == 15);
                e.bsy = 1'b1;
                e.fd  = (drop < 0) && (c == 16*nl);
                e.ur  = 1'b0;
            end else begin
                e = '{enc: 1'b0, rdy: 1'b0, bsy: 1'b1, fd: 1'b0,
                      ur: (drop >= 0) && (c == 16*nl + 1)};
            end
            v = (nxt < lim) && !(rst_at >= 0 && c > rst_at);
            @(posedge clk);
            #1;
            tx_valid = v;
            tx_data  = v ? pay[nxt] : 8'h00;
            tx_last  = v && (nxt == n - 1);
            rst      = (c == rst_at);
            exp_q.push_back(e);
            if (e.rdy && v) nxt++;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        logic [7:0]  pay[$];
        logic [15:0] w;
        int          last;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset encoded", {31'd0, encoded}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset underrun", {31'd0, underrun}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle tx_ready", {31'd0, tx_ready}, 32'd1);

        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model crc 123456789", crc32_model(pay), 32'hCBF43926);

        // Single byte 0xA5
        pay = '{8'hA5};
        run_frame(pay, -1, -1);
        chk("A5 frame_done cycle", first_from(fd_log, 0), FCS ? 208 : 144);
        chk("A5 frame_done count", count_range(fd_log, 0, fd_log.size() - 1), 1);
        for (int i = 0; i < PRE; i++) chk($sformatf("preamble byte %0d", i), dec_byte(1 + 16*i), 8'h55);
        chk("preamble halves", halves(1), 16'h6666);
        w = halves(113);
        chk("SFD halves", w, 16'h6665);
        chk("SFD tail 0101", {28'd0, w[3:0]}, 32'h5);
        chk("A5 payload halves", halves(129), 16'h6699);
        last = rdy_log.size() - 1;
        chk("A5 ready after gap index", last, FCS ? 401 : 337);
        chk("A5 ready after gap", {31'd0, rdy_log[last]}, 32'd1);
        chk("A5 gap zeros", count_range(enc_log, last - IFG, last - 1), 0);

        // Three back-to-back bytes
        pay = '{8'h01, 8'h02, 8'h03};
        run_frame(pay, -1, -1);
        chk("3B ready count", count_range(rdy_log, 1, rdy_log.size() - 2), 2);
        chk("3B first ready", first_from(rdy_log, 1), 144);
        chk("3B second ready", first_from(rdy_log, 145), 160);
        chk("3B byte0", dec_byte(129), 8'h01);
        chk("3B byte1", dec_byte(145), 8'h02);
        chk("3B byte2", dec_byte(161), 8'h03);
        chk("3B frame_done cycle", first_from(fd_log, 0), FCS ? 240 : 176);

        // Underrun after byte 0
        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(pay, 0, -1);
        chk("UR underrun count", count_range(ur_log, 0, ur_log.size() - 1), 1);
        chk("UR underrun cycle", first_from(ur_log, 0), 145);
        chk("UR no frame_done", count_range(fd_log, 0, fd_log.size() - 1), 0);
        chk("UR gap zeros", count_range(enc_log, 145, 145 + IFG - 1), 0);
        chk("UR ready after gap", {31'd0, rdy_log[145 + IFG]}, 32'd1);

        // Reset in the middle of payload byte 0
        pay = '{8'h3C, 8'h4B};
        run_frame(pay, -1, 135);
        chk("RST no underrun", count_range(ur_log, 0, ur_log.size() - 1), 0);
        chk("RST no frame_done", count_range(fd_log, 0, fd_log.size() - 1), 0);
        chk("RST encoded low", {31'd0, enc_log[136]}, 32'd0);
        chk("RST ready high", {31'd0, rdy_log[136]}, 32'd1);

`ifdef MANCHESTER_TX_FCS_EN
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(pay, -1, -1);
        chk("FCS byte0", dec_byte(273), 8'h26);
        chk("FCS byte1", dec_byte(289), 8'h39);
        chk("FCS byte2", dec_byte(305), 8'hF4);
        chk("FCS byte3", dec_byte(321), 8'hCB);
        chk("FCS frame_done cycle", first_from(fd_log, 0), 336);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
